// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: program counter, writable jump table
// and the req/done start/finish handshake that gates the core.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   req       - start request (level, 4-phase with done)
//   relj      - relative jump: pc + lut[how_high]
//   absj      - absolute jump: lut[how_high] (wins over relj)
//   how_high  - jump-table index used by relj/absj
//   lut_we    - jump-table write enable
//   lut_waddr - jump-table write index
//   lut_wdata - jump-table write data
//   prog_ctr  - current instruction address
//   run       - core enable, high only while running
//   done      - program finished, high only once halted
module fetch_sequencer #(
    parameter int D         = 12,
    parameter int LUT_W     = 5,
    parameter int DONE_ADDR = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             relj,
    input  logic             absj,
    input  logic [LUT_W-1:0] how_high,
    input  logic             lut_we,
    input  logic [LUT_W-1:0] lut_waddr,
    input  logic [D-1:0]     lut_wdata,
    output logic [D-1:0]     prog_ctr,
    output logic             run,
    output logic             done
);

    localparam int          DEPTH = 2 ** LUT_W;
    localparam logic [D-1:0] HALT = D'(DONE_ADDR);
    localparam logic [D-1:0] ONE  = D'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [D-1:0] lut [DEPTH];
    logic [D-1:0] target;

    // Combinational read: a jump in the same cycle as a write to the
    // same index sees the old entry.
    assign target = lut[how_high];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    // run/done are registered alongside the state so there is no
    // combinational path from req to done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            prog_ctr <= '0;
            run      <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    prog_ctr <= '0;
                    if (req) begin
                        state <= RUN;
                        run   <= 1'b1;
                    end
                end
                RUN: begin
                    if (prog_ctr == HALT) begin
                        state <= DONE;
                        run   <= 1'b0;
                        done  <= 1'b1;
                    end else if (absj) begin
                        prog_ctr <= target;
                    end else if (relj) begin
                        prog_ctr <= prog_ctr + target;
                    end else begin
                        prog_ctr <= prog_ctr + ONE;
                    end
                end
                DONE: begin
                    if (!req) begin
                        state    <= IDLE;
                        prog_ctr <= '0;
                        done     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    prog_ctr <= '0;
                    run      <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table,
// hand-written corner sequences and a randomized run against a model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        relj = 1'b0;
    logic        absj = 1'b0;
    logic [4:0]  how_high = '0;
    logic        lut_we = 1'b0;
    logic [4:0]  lut_waddr = '0;
    logic [11:0] lut_wdata = '0;

    logic [11:0] pc12;
    logic        run12, done12;
    logic [7:0]  pc8;
    logic        run8, done8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(rst_n), .req(req),
        .relj(relj), .absj(absj), .how_high(how_high),
        .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata),
        .prog_ctr(pc12), .run(run12), .done(done12)
    );

    fetch_sequencer #(.D(8), .LUT_W(5), .DONE_ADDR(200)) dut8 (
        .clk(clk), .reset(rst_n), .req(req),
        .relj(relj), .absj(absj), .how_high(how_high),
        .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata[7:0]),
        .prog_ctr(pc8), .run(run8), .done(done8)
    );

    // Reference model: mode 0=idle 1=running 2=finished
    int m_mode [2];
    int m_pc   [2];
    int m_lut  [2][32];

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_pc[k] = 0;
            for (int i = 0; i < 32; i++) m_lut[k][i] = 0;
        end
    endtask

    task automatic model_step(input int k, input int w, input int halt);
        int modulus;
        int tgt;
        modulus = 1 << w;
        tgt = m_lut[k][how_high];
        if (m_mode[k] == 0) begin
            m_pc[k] = 0;
            if (req) m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
            if (m_pc[k] == halt) m_mode[k] = 2;
            else if (absj) m_pc[k] = tgt;
            else if (relj) m_pc[k] = (m_pc[k] + tgt) % modulus;
            else m_pc[k] = (m_pc[k] + 1) % modulus;
        end else begin
            if (!req) begin
                m_mode[k] = 0;
                m_pc[k] = 0;
            end
        end
        if (lut_we) m_lut[k][lut_waddr] = int'(lut_wdata) % modulus;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 12, 128);
        model_step(1, 8, 200);
        #1;
    endtask

    task automatic idle_inputs();
        relj = 0; absj = 0; how_high = '0;
        lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        req = 0;
        rst_n = 0;
        #1;
        model_clear();
        chk("reset pc", 32'(pc12), 0);
        chk("reset run", 32'(run12), 0);
        chk("reset done", 32'(done12), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    typedef struct {
        logic        rq, rj, aj;
        logic [4:0]  hh;
        logic        we;
        logic [4:0]  wa;
        logic [11:0] wd;
        int          pc;
        logic        rn, dn;
    } vec_t;

    function automatic vec_t mk(logic rq, logic rj, logic aj, int hh,
                                logic we, int wa, int wd,
                                int pc, logic rn, logic dn);
        vec_t t;
        t.rq = rq; t.rj = rj; t.aj = aj; t.hh = 5'(hh);
        t.we = we; t.wa = 5'(wa); t.wd = 12'(wd);
        t.pc = pc; t.rn = rn; t.dn = dn;
        return t;
    endfunction

    vec_t tv[$];

    initial begin
        // Vector table: preload, start, climb to 10, then jumps
        tv.push_back(mk(0, 0, 0, 0, 1, 3, 40, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 4, 12'hFFB, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 7, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 1; i <= 10; i++)
            tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, i, 1, 0));
        tv.push_back(mk(1, 0, 1, 3, 0, 0, 0, 40, 1, 0));
        tv.push_back(mk(1, 1, 0, 4, 0, 0, 0, 35, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0, 0, 7, 1, 0));
        tv.push_back(mk(1, 0, 1, 1, 1, 1, 9, 7, 1, 0));
        tv.push_back(mk(1, 0, 1, 1, 0, 0, 0, 9, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0, 0, 9, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 10, 1, 0));

        do_reset();
        foreach (tv[i]) begin
            req = tv[i].rq; relj = tv[i].rj; absj = tv[i].aj;
            how_high = tv[i].hh; lut_we = tv[i].we;
            lut_waddr = tv[i].wa; lut_wdata = tv[i].wd;
            cycle();
            chk($sformatf("vec%0d pc", i), 32'(pc12), 32'(tv[i].pc));
            chk($sformatf("vec%0d run", i), 32'(run12), 32'(tv[i].rn));
            chk($sformatf("vec%0d done", i), 32'(done12), 32'(tv[i].dn));
        end

        // Straight-line run to the halt address, then handshake
        do_reset();
        req = 1;
        cycle();
        chk("start pc", 32'(pc12), 0);
        chk("start run", 32'(run12), 1);
        for (int i = 1; i <= 128; i++) begin
            cycle();
            chk($sformatf("climb pc%0d", i), 32'(pc12), 32'(i));
            chk("climb done", 32'(done12), 0);
        end
        cycle();
        chk("halt done", 32'(done12), 1);
        chk("halt run", 32'(run12), 0);
        chk("halt pc", 32'(pc12), 128);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold done", 32'(done12), 1);
            chk("hold pc", 32'(pc12), 128);
        end
        req = 0;
        cycle();
        chk("release done", 32'(done12), 0);
        chk("release pc", 32'(pc12), 0);
        chk("release run", 32'(run12), 0);
        req = 1;
        cycle();
        chk("restart run", 32'(run12), 1);
        cycle();
        chk("restart pc", 32'(pc12), 1);

        // Narrow instance: wrap on relative jump and on increment
        do_reset();
        lut_we = 1; lut_waddr = 5; lut_wdata = 250;
        cycle();
        lut_waddr = 2; lut_wdata = 100;
        cycle();
        lut_waddr = 6; lut_wdata = 255;
        cycle();
        lut_we = 0; req = 1;
        cycle();
        chk("d8 start run", 32'(run8), 1);
        absj = 1; how_high = 5;
        cycle();
        chk("d8 abs pc", 32'(pc8), 250);
        absj = 0; relj = 1; how_high = 2;
        cycle();
        chk("d8 rel wrap pc", 32'(pc8), 94);
        relj = 0; absj = 1; how_high = 6;
        cycle();
        chk("d8 abs255 pc", 32'(pc8), 255);
        absj = 0;
        cycle();
        chk("d8 inc wrap pc", 32'(pc8), 0);

        // Asynchronous reset in the middle of a run
        do_reset();
        lut_we = 1; lut_waddr = 7; lut_wdata = 99;
        cycle();
        lut_we = 0; req = 1;
        cycle();
        for (int i = 1; i <= 57; i++) cycle();
        chk("pre-reset pc", 32'(pc12), 57);
        #2;
        rst_n = 0;
        #1;
        model_clear();
        chk("async pc", 32'(pc12), 0);
        chk("async run", 32'(run12), 0);
        chk("async done", 32'(done12), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        req = 1;
        cycle();
        chk("post-reset run", 32'(run12), 1);
        absj = 1; how_high = 7;
        cycle();
        chk("cleared lut pc", 32'(pc12), 0);
        absj = 0;
        cycle();
        chk("post-reset inc", 32'(pc12), 1);

        // Randomized traffic on both instances against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req = ($urandom_range(0, 19) != 0);
            absj = ($urandom_range(0, 9) == 0);
            relj = ($urandom_range(0, 9) == 0);
            how_high = 5'($urandom_range(0, 31));
            lut_we = ($urandom_range(0, 4) == 0);
            lut_waddr = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: lut_wdata = 12'd128;
                1: lut_wdata = 12'd200;
                2: lut_wdata = 12'($urandom_range(0, 15));
                default: lut_wdata = 12'($urandom_range(0, 4095));
            endcase
            cycle();
            chk("rnd pc12", 32'(pc12), 32'(m_pc[0]));
            chk("rnd run12", 32'(run12), 32'(m_mode[0] == 1));
            chk("rnd done12", 32'(done12), 32'(m_mode[0] == 2));
            chk("rnd pc8", 32'(pc8), 32'(m_pc[1]));
            chk("rnd run8", 32'(run8), 32'(m_mode[1] == 1));
            chk("rnd done8", 32'(done8), 32'(m_mode[1] == 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
